// File: rtl/pong_score_overlay.sv
// Pong scoreboard: counts points from hit edges and tells the RGB mux whether
// the current pixel sits on a lit segment of one of the four score digits.
module pong_score_overlay #(
    parameter logic [10:0] Y0        = 11'd25,
    parameter logic [10:0] X_L_TENS  = 11'd242,
    parameter logic [10:0] X_L_UNITS = 11'd276,
    parameter logic [10:0] X_R_TENS  = 11'd340,
    parameter logic [10:0] X_R_UNITS = 11'd374
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_hit,
    input  logic       right_hit,
    input  logic       show,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [4:0] score_left,
    output logic [4:0] score_right,
    output logic       seg_on
);

    logic prev_left, prev_right;
    logic left_evt, right_evt;

    assign left_evt  = left_hit  & ~prev_left;
    assign right_evt = right_hit & ~prev_right;

    // The ball hitting one wall scores for the player on the opposite side.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_left   <= 1'b0;
            prev_right  <= 1'b0;
            score_left  <= 5'd0;
            score_right <= 5'd0;
        end else begin
            prev_left  <= left_hit;
            prev_right <= right_hit;
            if (right_evt && score_left != 5'd31)
                score_left <= score_left + 5'd1;
            if (left_evt && score_right != 5'd31)
                score_right <= score_right + 5'd1;
        end
    end

    // {tens, units} for a score in 0..31
    function automatic logic [7:0] split(input logic [4:0] s);
        logic [3:0] t, u;
        if (s >= 5'd30) begin
            t = 4'd3; u = 4'(s - 5'd30);
        end else if (s >= 5'd20) begin
            t = 4'd2; u = 4'(s - 5'd20);
        end else if (s >= 5'd10) begin
            t = 4'd1; u = 4'(s - 5'd10);
        end else begin
            t = 4'd0; u = s[3:0];
        end
        return {t, u};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // 24x44 box at (x0, Y0), segments 4 px thick
    function automatic logic seg_hit(input logic [6:0] p, input logic [10:0] px,
                                     input logic [10:0] py, input logic [10:0] x0);
        logic       in_box;
        logic [10:0] rx, ry;
        logic [6:0] hit;
        in_box = (px >= x0) && (px <= x0 + 11'd23) && (py >= Y0) && (py <= Y0 + 11'd43);
        rx = px - x0;
        ry = py - Y0;
        hit[0] = (ry <= 11'd3);
        hit[1] = (rx >= 11'd20) && (ry <= 11'd23);
        hit[2] = (rx >= 11'd20) && (ry >= 11'd20);
        hit[3] = (ry >= 11'd40);
        hit[4] = (rx <= 11'd3) && (ry >= 11'd20);
        hit[5] = (rx <= 11'd3) && (ry <= 11'd23);
        hit[6] = (ry >= 11'd20) && (ry <= 11'd23);
        return in_box && |(p & hit);
    endfunction

    logic [7:0]  dl, dr;
    logic [10:0] px, py;

    always_comb begin
        dl = split(score_left);
        dr = split(score_right);
        px = {1'b0, x};
        py = {1'b0, y};
        seg_on = show & (seg_hit(seg7(dl[7:4]), px, py, X_L_TENS)
                       | seg_hit(seg7(dl[3:0]), px, py, X_L_UNITS)
                       | seg_hit(seg7(dr[7:4]), px, py, X_R_TENS)
                       | seg_hit(seg7(dr[3:0]), px, py, X_R_UNITS));
    end

endmodule

// File: tb/tb_pong_score_overlay.sv
// Directed bench for pong_score_overlay: scoring edges, saturation, reset and glyph pixels.
module tb_pong_score_overlay;

    logic       clk = 1'b0;
    logic       reset, left_hit, right_hit, show;
    logic [9:0] x, y;
    logic [4:0] score_left, score_right;
    logic       seg_on;
    int         n_cmp = 0;
    int         n_bad = 0;

    pong_score_overlay dut (
        .clk(clk), .reset(reset), .left_hit(left_hit), .right_hit(right_hit),
        .show(show), .x(x), .y(y),
        .score_left(score_left), .score_right(score_right), .seg_on(seg_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic l, input logic r);
        left_hit = l; right_hit = r;
        tick();
        left_hit = 1'b0; right_hit = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pix(input string tag, input int px, input int py, input int exp);
        x = 10'(px); y = 10'(py);
        #1;
        chk(tag, int'(seg_on), exp);
    endtask

    initial begin
        reset = 1'b1; left_hit = 1'b0; right_hit = 1'b0; show = 1'b0;
        x = '0; y = '0;
        tick();
        reset = 1'b0;
        chk("reset_left", score_left, 0);
        chk("reset_right", score_right, 0);

        // right_hit held 3 cycles counts once
        right_hit = 1'b1;
        repeat (3) tick();
        right_hit = 1'b0;
        tick();
        chk("rhit3_left", score_left, 1);
        chk("rhit3_right", score_right, 0);

        // single-cycle left_hit, visible right after the sampling edge
        left_hit = 1'b1;
        tick();
        chk("lhit_latency", score_right, 1);
        left_hit = 1'b0;
        tick();

        right_hit = 1'b1;
        repeat (100) tick();
        right_hit = 1'b0;
        tick();
        chk("held100_left", score_left, 2);

        pulse(1'b1, 1'b1);
        chk("both_left", score_left, 3);
        chk("both_right", score_right, 2);

        reset = 1'b1; right_hit = 1'b1; left_hit = 1'b1;
        tick();
        reset = 1'b0; right_hit = 1'b0; left_hit = 1'b0;
        chk("rst_wins_left", score_left, 0);
        chk("rst_wins_right", score_right, 0);
        tick();

        // hit already high on the first edge after reset counts
        reset = 1'b1; right_hit = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_hit", score_left, 1);
        right_hit = 1'b0;
        tick();

        do_reset();
        repeat (35) pulse(1'b0, 1'b1);
        chk("sat_left", score_left, 31);
        pulse(1'b0, 1'b1);
        chk("sat_hold", score_left, 31);
        chk("sat_right", score_right, 0);

        do_reset();
        repeat (12) pulse(1'b0, 1'b1);
        repeat (7)  pulse(1'b1, 1'b0);
        chk("glyph_left", score_left, 12);
        chk("glyph_right", score_right, 7);

        show = 1'b1;
        pix("l_tens_b", 262, 30, 1);
        pix("l_tens_a_off", 244, 27, 0);
        pix("l_units_a", 280, 26, 1);
        pix("l_units_f_off", 278, 35, 0);
        pix("r_tens_a", 350, 26, 1);
        pix("r_tens_g_off", 345, 45, 0);
        pix("r_units_b", 395, 42, 1);
        pix("r_units_mid", 384, 42, 0);
        pix("r_units_c", 395, 50, 1);
        pix("r_units_e_off", 375, 50, 0);
        pix("oob_origin", 0, 0, 0);
        pix("oob_left", 241, 25, 0);
        pix("oob_gap", 266, 25, 0);
        pix("oob_below", 242, 69, 0);
        pix("l_tens_c_edge", 265, 68, 1);

        show = 1'b0;
        pix("hide_l_tens", 262, 30, 0);
        pix("hide_l_units", 280, 26, 0);
        pix("hide_r_tens", 350, 26, 0);
        pix("hide_r_units", 395, 42, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
